uart_tx_queue: RTL and testbench

- Byte FIFO plus issue FSM between the CPU/terminal write path and the 8N2 async UART transmitter.
- Accepts bytes in single-cycle writes, buffers them, and hands them one at a time to the transmitter using its start/busy handshake.
- Decouples CPU character output (Apple-1 display writes) from the 115200-baud line rate.

---
 rtl/uart_tx_queue.sv | 155 +++++++++++++++
 tb/tb_uart_tx_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding an 8N2 UART transmitter through a start/busy handshake.
// Optional CR->CRLF expansion is enabled by defining UART_TX_CRLF_EN.
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef UART_TX_CRLF_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE, S_LF_PEND} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_t;
`endif

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic                  r_tx_start;
  logic [7:0]            r_tx_data;
  logic                  r_wait;
  state_t                r_state;
  state_t                w_state_next;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_issue_lf;
  logic [7:0]            w_head;

  assign w_full  = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];
  // flush discards a same-cycle write silently
  assign w_wr    = wr_en && !w_full && !flush;

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en && w_full && !flush;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_wr, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_next;
      // second consecutive cycle in WAIT_BUSY without busy ends the wait
      r_wait     <= (r_state == S_WAIT_BUSY) && (w_state_next == S_WAIT_BUSY);
      r_tx_start <= w_pop || w_issue_lf;
      if (w_pop) begin
        r_tx_data <= w_head;
      end else if (w_issue_lf) begin
        r_tx_data <= 8'h0A;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !tx_busy) begin
          w_state_next = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_next = S_WAIT_DONE;
        end else if (r_wait) begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_TX_CRLF_EN
          w_state_next = (r_tx_data == 8'h0D) ? S_LF_PEND : S_IDLE;
`else
          w_state_next = S_IDLE;
`endif
        end
      end
`ifdef UART_TX_CRLF_EN
      S_LF_PEND: begin
        if (!tx_busy) begin
          w_state_next = S_WAIT_BUSY;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop      = (r_state == S_IDLE) && !w_empty && !tx_busy;
    w_issue_lf = 1'b0;
`ifdef UART_TX_CRLF_EN
    w_issue_lf = (r_state == S_LF_PEND) && !tx_busy;
`endif
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a behavioural transmitter busy model.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  // 0: responsive transmitter, 1: busy forced high, 2: dead (never busy)
  int   mode = 0;
  int   busy_len = 4;
  logic m_busy = 1'b0;
  int   m_cnt = 0;

  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  assign tx_busy = (mode == 1) ? 1'b1 : ((mode == 0) ? m_busy : 1'b0);

  uart_tx_queue #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always @(posedge clk) begin
    if (tx_start && mode == 0) begin
      m_busy <= 1'b1;
      m_cnt  <= busy_len;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && tx_start) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tx_start: got data %0h expected no start", tx_data);
      end else begin
        chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        chk("busy_low_at_start", 32'(tx_busy), 32'd0);
      end
    end
  end

  task automatic wait_idle(input int max_cycles);
    int i = 0;
    int quiet = 0;
    while (quiet < 3 && i < max_cycles) begin
      @(negedge clk);
      i++;
      if (exp_q.size() == 0 && !tx_busy && !tx_start) quiet++;
      else quiet = 0;
    end
    chk("drain_in_time", 32'(i < max_cycles), 32'd1);
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    rst = 1'b0;
    @(negedge clk);

    // single byte latency
    exp_q.push_back(8'h41);
    write_byte(8'h41);
    chk("lat_count_1", 32'(count), 32'd1);
    chk("lat_start_early", 32'(tx_start), 32'd0);
    @(negedge clk);
    chk("lat_start", 32'(tx_start), 32'd1);
    chk("lat_count_0", 32'(count), 32'd0);
    chk("lat_empty", 32'(empty), 32'd1);
    @(negedge clk);
    chk("start_one_cycle", 32'(tx_start), 32'd0);
    wait_idle(50);

    // fill to full while busy, then overflow
    mode = 1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      exp_q.push_back(8'(i));
      @(negedge clk);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    @(negedge clk);
    chk("ovf_one_cycle", 32'(overflow), 32'd0);
    mode = 0;
    busy_len = 3;
    wait_idle(400);
    chk("fill_drained_empty", 32'(empty), 32'd1);

    // flush with in-flight byte
    busy_len = 30;
    exp_q.push_back(8'h50);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h50;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_data = 8'h61 + 8'(i);
    end
    @(negedge clk);
    wr_data = 8'h33;
    flush = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_no_ovf", 32'(overflow), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    wait_idle(200);
    chk("flush_after_count", 32'(count), 32'd0);

    // dead transmitter: WAIT_BUSY timeout
    mode = 2;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h10;
    @(negedge clk);
    wr_data = 8'h20;
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle(50);
    chk("dead_empty", 32'(empty), 32'd1);

    // CR handling
    mode = 0;
    busy_len = 4;
    exp_q.push_back(8'h0D);
`ifdef UART_TX_CRLF_EN
    exp_q.push_back(8'h0A);
`endif
    exp_q.push_back(8'h42);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h0D;
    @(negedge clk);
    wr_data = 8'h42;
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle(200);
    chk("cr_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
